pong_engine: RTL and testbench
==============================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Single clock CLK; reset RST is synchronous and active-high; all state changes occur on the rising edge of CLK.
REQ-002 COLS, 8, field width in cells; XW = $clog2(COLS).
REQ-003 ROWS, 16, field height in cells; YW = $clog2(ROWS).
REQ-004 BAR_LEN, 3, bar length in cells; legal range 2..COLS-1.
REQ-005 BAR1_Y, ROWS-4, row of player-1 bar, near the high-y end.
REQ-006 BAR2_Y, 3, row of player-2 bar, near the low-y end.
REQ-007 BALL_DIV, 4000000, CLK cycles per ball step.
REQ-008 BTN_DIV, 2000, CLK cycles per button sample.
REQ-009 WIN_SCORE, 9, points that end a game; legal range 1..15.
REQ-010 CLK  in  1  system clock.
REQ-011 RST  in  1  synchronous active-high reset.
REQ-012 PUSH  in  4  buttons: [1] bar1 left, [0] bar1 right, [3] bar2 left, [2] bar2 right.
REQ-013 START  in  1  level; starts a game, releases a serve, or restarts after game over.
REQ-014 bar1_x, bar2_x  out  XW each  leftmost cell of each bar.
REQ-015 ball_x  out  XW; ball_y  out  YW  ball position.
REQ-016 score1, score2  out  4 each  player scores.
REQ-017 state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
REQ-018 point_pulse  out  1  high for one cycle per scored point.

Function
REQ-019 Ball tick: a counter runs 0..BALL_DIV-1 and wraps; it asserts for one cycle at BALL_DIV-1. Button tick works the same way with BTN_DIV.
REQ-020 On each button tick, each PUSH bit shifts into a 2-bit history register. A history value of 01 is a press event.
REQ-021 A press moves the bar one cell. Left has priority over right when both press in the same tick. Bars clamp to 0..COLS-BAR_LEN; a press at the limit is ignored.
REQ-022 Bars move only in SERVE and PLAY; presses in other states are discarded, but the history registers still update.
REQ-023 Ball state: vy (1 = y increasing toward BAR1 side) and dx in {-1, 0, +1}.
REQ-024 IDLE: START=1 -> SERVE with server = player 1.
REQ-025 SERVE: the ball tracks the server's bar every cycle.
- x = bar_x + BAR_LEN/2, y = server's bar row.
- dx = 0; vy points away from the server (player 1 -> vy=0).
- START=1 -> PLAY.
REQ-026 PLAY: on a ball tick, hit check first.
- Hit condition: ball_y == row of the bar the ball moves toward AND bar_x <= ball_x <= bar_x+BAR_LEN-1.
- On a hit, vy inverts and the ball holds position for that tick.
- dx is set by hit segment: -1 for the leftmost cell, +1 for the rightmost cell, 0 for the interior.
REQ-027 With no hit: y steps by vy. If x+dx would leave 0..COLS-1, dx negates first and x steps by the new dx (wall reflection).
REQ-028 Point condition, checked on a ball tick before movement:
- ball_y == ROWS-1 with vy=1 -> point to player 2.
- ball_y == 0 with vy=0 -> point to player 1.
- In both cases -> POINT; the ball does not move.
REQ-029 POINT lasts exactly one cycle: the scorer's score increments and point_pulse=1.
- Next state is GAMEOVER if the new score == WIN_SCORE.
- Otherwise next state is SERVE, with server = the player who lost the point.
REQ-030 GAMEOVER: ball and bars hold. START=1 -> scores clear to 0, server = player 1 -> SERVE.
REQ-031 START is ignored in PLAY and POINT. In SERVE and GAMEOVER it acts at most once per entry into the state.
REQ-032 Scores never exceed WIN_SCORE; no wrap-around.

Reset
REQ-033 RST=1 has priority over all events. It produces:
- state=IDLE, both tick counters=0, all button histories=00;
- bar1_x=0, bar2_x=COLS-BAR_LEN;
- ball_x=BAR_LEN/2, ball_y=BAR1_Y, vy=0, dx=0;
- score1=score2=0, point_pulse=0, server=player 1.
REQ-034 RST asserted mid-PLAY or mid-POINT gives the same values on the next edge; no point is awarded.

Verification (COLS=8, ROWS=16, BAR_LEN=3, BALL_DIV=4, BTN_DIV=1, WIN_SCORE=2)
REQ-035 Reset, then START, then START -> SERVE with ball (1,12). PLAY then ball_y decrements once every 4 cycles, x stays 1.
REQ-036 Bar2 at x=5, ball (7,3) with vy=0 -> hit on the rightmost cell: vy=1, dx=+1, ball holds. Next step is wall reflect to (6,4) with dx=-1.
REQ-037 Bar1 at x=0, ball travelling vy=1 at x=5 -> no hit at y=12. At y=15 a point goes to player 2: point_pulse for one cycle, score2=1, SERVE from bar1.
REQ-038 Hold PUSH[1] and PUSH[0] together with bar1 at 0 -> bar1 stays at 0. Release then press PUSH[0] 6 times -> bar1 stops at 5.
REQ-039 Player 1 scores twice -> score1=2, GAMEOVER. START -> scores 0, SERVE.
REQ-040 RST mid-PLAY with score1=1 -> all REQ-033 values on the next edge.

Source files
------------

// File: rtl/pong_engine.sv
// Pong engine: bars, ball motion, scoring and game FSM on a COLS x ROWS cell grid.
// All state updates on the CLK edge after a tick or START; no backpressure, inputs are sampled levels.
module pong_engine #(
    parameter int COLS      = 8,
    parameter int ROWS      = 16,
    parameter int BAR_LEN   = 3,
    parameter int BAR1_Y    = ROWS - 4,
    parameter int BAR2_Y    = 3,
    parameter int BALL_DIV  = 4000000,
    parameter int BTN_DIV   = 2000,
    parameter int WIN_SCORE = 9,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [3:0]    PUSH,
    input  logic          START,
    output logic [XW-1:0] bar1_x,
    output logic [XW-1:0] bar2_x,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic [3:0]    score1,
    output logic [3:0]    score2,
    output logic [2:0]    state,
    output logic          point_pulse
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int BLW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
    localparam int TLW = (BTN_DIV > 1) ? $clog2(BTN_DIV) : 1;
    localparam logic [XW-1:0] BAR_MAX = XW'(COLS - BAR_LEN);
    localparam logic [XW-1:0] X_MAX   = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(ROWS - 1);
    localparam logic [YW-1:0] ROW1    = YW'(BAR1_Y);
    localparam logic [YW-1:0] ROW2    = YW'(BAR2_Y);
    localparam logic [3:0]    WIN     = 4'(WIN_SCORE);
    localparam logic [1:0]    DX_0    = 2'b00;
    localparam logic [1:0]    DX_R    = 2'b01;
    localparam logic [1:0]    DX_L    = 2'b10;

    state_t          st_q, st_d;
    logic [BLW-1:0]  ball_cnt;
    logic [TLW-1:0]  btn_cnt;
    logic            ball_tick, btn_tick;
    logic [3:0][1:0] hist_q, hist_d;
    logic [3:0]      press;
    logic [XW-1:0]   bar1_d, bar2_d, bx_d, tgt_bar, tgt_end, srv_bar;
    logic [YW-1:0]   by_d;
    logic            vy_q, vy_d, srv_q, srv_d, hit;
    logic [1:0]      dx_q, dx_d;
    logic [3:0]      s1_d, s2_d;

    assign ball_tick = (ball_cnt == BLW'(BALL_DIV - 1));
    assign btn_tick  = (btn_cnt == TLW'(BTN_DIV - 1));

    always_comb begin
        hist_d = hist_q;
        press  = '0;
        for (int i = 0; i < 4; i++) begin
            hist_d[i] = btn_tick ? {hist_q[i][0], PUSH[i]} : hist_q[i];
            press[i]  = btn_tick && (hist_d[i] == 2'b01);
        end
    end

    // srv_q: 0 = player 1 serves, 1 = player 2 serves (also equals the serve vy)
    assign tgt_bar = vy_q ? bar1_x : bar2_x;
    assign tgt_end = tgt_bar + XW'(BAR_LEN - 1);
    assign hit     = (ball_y == (vy_q ? ROW1 : ROW2)) && (ball_x >= tgt_bar) && (ball_x <= tgt_end);
    assign srv_bar = srv_q ? bar2_x : bar1_x;

    always_comb begin
        st_d   = st_q;
        bar1_d = bar1_x;
        bar2_d = bar2_x;
        bx_d   = ball_x;
        by_d   = ball_y;
        vy_d   = vy_q;
        dx_d   = dx_q;
        s1_d   = score1;
        s2_d   = score2;
        srv_d  = srv_q;

        if (st_q == S_SERVE || st_q == S_PLAY) begin
            if (press[1]) begin
                if (bar1_x != '0) bar1_d = bar1_x - 1'b1;
            end else if (press[0]) begin
                if (bar1_x != BAR_MAX) bar1_d = bar1_x + 1'b1;
            end
            if (press[3]) begin
                if (bar2_x != '0) bar2_d = bar2_x - 1'b1;
            end else if (press[2]) begin
                if (bar2_x != BAR_MAX) bar2_d = bar2_x + 1'b1;
            end
        end

        case (st_q)
            S_IDLE: begin
                if (START) begin
                    srv_d = 1'b0;
                    st_d  = S_SERVE;
                end
            end
            S_SERVE: begin
                bx_d = srv_bar + XW'(BAR_LEN / 2);
                by_d = srv_q ? ROW2 : ROW1;
                vy_d = srv_q;
                dx_d = DX_0;
                if (START) st_d = S_PLAY;
            end
            S_PLAY: begin
                if (ball_tick) begin
                    if (hit) begin
                        vy_d = ~vy_q;
                        if (ball_x == tgt_bar)      dx_d = DX_L;
                        else if (ball_x == tgt_end) dx_d = DX_R;
                        else                        dx_d = DX_0;
                    end else if (vy_q && ball_y == Y_MAX) begin
                        if (score2 != WIN) s2_d = score2 + 4'd1;
                        srv_d = 1'b0;
                        st_d  = S_POINT;
                    end else if (!vy_q && ball_y == '0) begin
                        if (score1 != WIN) s1_d = score1 + 4'd1;
                        srv_d = 1'b1;
                        st_d  = S_POINT;
                    end else begin
                        by_d = vy_q ? ball_y + 1'b1 : ball_y - 1'b1;
                        case (dx_q)
                            DX_R: begin
                                if (ball_x == X_MAX) begin
                                    dx_d = DX_L;
                                    bx_d = ball_x - 1'b1;
                                end else begin
                                    bx_d = ball_x + 1'b1;
                                end
                            end
                            DX_L: begin
                                if (ball_x == '0) begin
                                    dx_d = DX_R;
                                    bx_d = ball_x + 1'b1;
                                end else begin
                                    bx_d = ball_x - 1'b1;
                                end
                            end
                            default: bx_d = ball_x;
                        endcase
                    end
                end
            end
            // the loser already sits in srv_q, so the scorer is the other player
            S_POINT: st_d = (((srv_q ? score1 : score2) == WIN) ? S_OVER : S_SERVE);
            S_OVER: begin
                if (START) begin
                    s1_d  = '0;
                    s2_d  = '0;
                    srv_d = 1'b0;
                    st_d  = S_SERVE;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q     <= S_IDLE;
            ball_cnt <= '0;
            btn_cnt  <= '0;
            hist_q   <= '0;
            bar1_x   <= '0;
            bar2_x   <= BAR_MAX;
            ball_x   <= XW'(BAR_LEN / 2);
            ball_y   <= ROW1;
            vy_q     <= 1'b0;
            dx_q     <= DX_0;
            score1   <= '0;
            score2   <= '0;
            srv_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            ball_cnt <= ball_tick ? '0 : ball_cnt + 1'b1;
            btn_cnt  <= btn_tick ? '0 : btn_cnt + 1'b1;
            hist_q   <= hist_d;
            bar1_x   <= bar1_d;
            bar2_x   <= bar2_d;
            ball_x   <= bx_d;
            ball_y   <= by_d;
            vy_q     <= vy_d;
            dx_q     <= dx_d;
            score1   <= s1_d;
            score2   <= s2_d;
            srv_q    <= srv_d;
        end
    end

    assign state       = st_q;
    assign point_pulse = (st_q == S_POINT);
endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: directed vector table and scenarios plus random play against a cell-level game model.
module tb_pong_engine;
    localparam int COLS = 8, ROWS = 16, BAR_LEN = 3, BALL_DIV = 4, BTN_DIV = 1, WIN_SCORE = 2;
    localparam int B1Y = ROWS - 4, B2Y = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] PUSH = 4'h0;
    logic       START = 1'b0;
    logic [2:0] bar1_x, bar2_x, ball_x;
    logic [3:0] ball_y, score1, score2;
    logic [2:0] state;
    logic       point_pulse;

    pong_engine #(
        .COLS(COLS), .ROWS(ROWS), .BAR_LEN(BAR_LEN), .BAR1_Y(B1Y), .BAR2_Y(B2Y),
        .BALL_DIV(BALL_DIV), .BTN_DIV(BTN_DIV), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .START(START),
        .bar1_x(bar1_x), .bar2_x(bar2_x), .ball_x(ball_x), .ball_y(ball_y),
        .score1(score1), .score2(score2), .state(state), .point_pulse(point_pulse)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Game model: plain integers, srv is the serving player number (1 or 2), dx in {-1,0,1}
    int m_st, m_b1, m_b2, m_bx, m_by, m_vy, m_dx, m_s1, m_s2, m_srv, m_bcnt, m_tcnt;
    int m_hist[4];

    typedef struct {
        bit       rst;
        bit [3:0] push;
        bit       start;
        int       n;
        int       st, b1, b2, bx, by, s1, s2;
    } vec_t;
    vec_t tbl[10];

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int move_bar(int b, bit l, bit r);
        if (l) return (b > 0) ? b - 1 : b;
        if (r) return (b < COLS - BAR_LEN) ? b + 1 : b;
        return b;
    endfunction

    task automatic model_step();
        int  ob1, ob2, trow, tbar;
        bit  btick, ttick;
        bit [3:0] pr;
        if (RST) begin
            m_st = 0; m_bcnt = 0; m_tcnt = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
            m_b1 = 0; m_b2 = COLS - BAR_LEN; m_bx = BAR_LEN / 2; m_by = B1Y;
            m_vy = 0; m_dx = 0; m_s1 = 0; m_s2 = 0; m_srv = 1;
            return;
        end
        btick = (m_bcnt == BALL_DIV - 1);
        m_bcnt = btick ? 0 : m_bcnt + 1;
        ttick = (m_tcnt == BTN_DIV - 1);
        m_tcnt = ttick ? 0 : m_tcnt + 1;
        pr = '0;
        if (ttick) begin
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = (m_hist[i] % 2) * 2 + int'(PUSH[i]);
                pr[i] = (m_hist[i] == 1);
            end
        end
        ob1 = m_b1;
        ob2 = m_b2;
        if (m_st == 1 || m_st == 2) begin
            m_b1 = move_bar(m_b1, pr[1], pr[0]);
            m_b2 = move_bar(m_b2, pr[3], pr[2]);
        end
        case (m_st)
            0: if (START) begin m_srv = 1; m_st = 1; end
            1: begin
                m_bx = ((m_srv == 1) ? ob1 : ob2) + BAR_LEN / 2;
                m_by = (m_srv == 1) ? B1Y : B2Y;
                m_vy = (m_srv == 1) ? 0 : 1;
                m_dx = 0;
                if (START) m_st = 2;
            end
            2: if (btick) begin
                trow = m_vy ? B1Y : B2Y;
                tbar = m_vy ? ob1 : ob2;
                if (m_by == trow && m_bx >= tbar && m_bx <= tbar + BAR_LEN - 1) begin
                    m_vy = 1 - m_vy;
                    m_dx = (m_bx == tbar) ? -1 : ((m_bx == tbar + BAR_LEN - 1) ? 1 : 0);
                end else if (m_vy == 1 && m_by == ROWS - 1) begin
                    if (m_s2 < WIN_SCORE) m_s2++;
                    m_srv = 1; m_st = 3;
                end else if (m_vy == 0 && m_by == 0) begin
                    if (m_s1 < WIN_SCORE) m_s1++;
                    m_srv = 2; m_st = 3;
                end else begin
                    m_by += m_vy ? 1 : -1;
                    if (m_bx + m_dx < 0 || m_bx + m_dx > COLS - 1) m_dx = -m_dx;
                    m_bx += m_dx;
                end
            end
            3: m_st = (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) ? 4 : 1;
            4: if (START) begin m_s1 = 0; m_s2 = 0; m_srv = 1; m_st = 1; end
            default: m_st = 0;
        endcase
    endtask

    task automatic step();
        bit ok;
        @(posedge CLK);
        model_step();
        #1;
        cyc++;
        ok = (int'(state) == m_st) && (int'(bar1_x) == m_b1) && (int'(bar2_x) == m_b2) &&
             (int'(ball_x) == m_bx) && (int'(ball_y) == m_by) && (int'(score1) == m_s1) &&
             (int'(score2) == m_s2) && (point_pulse == (m_st == 3));
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL model cycle %0d: got st=%0d b1=%0d b2=%0d ball=(%0d,%0d) s=%0d/%0d pp=%0d, expected st=%0d b1=%0d b2=%0d ball=(%0d,%0d) s=%0d/%0d pp=%0d",
                     cyc, state, bar1_x, bar2_x, ball_x, ball_y, score1, score2, point_pulse,
                     m_st, m_b1, m_b2, m_bx, m_by, m_s1, m_s2, (m_st == 3));
        end
    endtask

    task automatic press(int idx, int n);
        for (int k = 0; k < n; k++) begin
            PUSH = 4'h0;
            PUSH[idx] = 1'b1;
            step();
            PUSH = 4'h0;
            step();
        end
    endtask

    task automatic wait_state(string name, int s, int limit);
        for (int i = 0; i < limit && int'(state) != s; i++) step();
        check(name, int'(state), s);
    endtask

    task automatic wait_y(string name, int y, int limit);
        for (int i = 0; i < limit && int'(ball_y) != y; i++) step();
        check(name, int'(ball_y), y);
    endtask

    task automatic check_ball(string name, int x, int y);
        check({name, "_x"}, int'(ball_x), x);
        check({name, "_y"}, int'(ball_y), y);
    endtask

    initial begin
        tbl = '{
            '{1'b1, 4'h0, 1'b0, 2, 0, 0, 5, 1, 12, 0, 0},
            '{1'b0, 4'h0, 1'b1, 1, 1, 0, 5, 1, 12, 0, 0},
            '{1'b0, 4'h0, 1'b1, 1, 2, 0, 5, 1, 12, 0, 0},
            '{1'b0, 4'h0, 1'b0, 1, 2, 0, 5, 1, 12, 0, 0},
            '{1'b0, 4'h0, 1'b0, 1, 2, 0, 5, 1, 11, 0, 0},
            '{1'b0, 4'h0, 1'b0, 4, 2, 0, 5, 1, 10, 0, 0},
            '{1'b0, 4'h0, 1'b0, 4, 2, 0, 5, 1, 9,  0, 0},
            '{1'b0, 4'h3, 1'b0, 1, 2, 0, 5, 1, 9,  0, 0},
            '{1'b0, 4'h3, 1'b0, 2, 2, 0, 5, 1, 9,  0, 0},
            '{1'b0, 4'h0, 1'b0, 1, 2, 0, 5, 1, 8,  0, 0}
        };

        // reset, serve, straight climb, simultaneous left+right at the left limit
        for (int i = 0; i < 10; i++) begin
            RST = tbl[i].rst; PUSH = tbl[i].push; START = tbl[i].start;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
            check($sformatf("vec%0d_bar1", i), int'(bar1_x), tbl[i].b1);
            check($sformatf("vec%0d_bar2", i), int'(bar2_x), tbl[i].b2);
            check($sformatf("vec%0d_ball_x", i), int'(ball_x), tbl[i].bx);
            check($sformatf("vec%0d_ball_y", i), int'(ball_y), tbl[i].by);
            check($sformatf("vec%0d_score1", i), int'(score1), tbl[i].s1);
            check($sformatf("vec%0d_score2", i), int'(score2), tbl[i].s2);
        end

        // six right presses saturate bar1 at COLS-BAR_LEN
        for (int k = 0; k < 6; k++) begin
            press(0, 1);
            check($sformatf("bar1_press%0d", k), int'(bar1_x), (k + 1 > 5) ? 5 : k + 1);
        end

        // ball at x=1 misses bar2 (5..7) and player 1 scores at the top wall
        wait_state("pointA_state", 3, 200);
        check("pointA_pulse", int'(point_pulse), 1);
        check("pointA_score1", int'(score1), 1);
        check("pointA_score2", int'(score2), 0);
        check_ball("pointA_ball", 1, 0);
        step();
        check("pointA_serve", int'(state), 1);
        check("pointA_pulse_off", int'(point_pulse), 0);
        step();
        check_ball("serve_bar2", 6, 3);

        // bar2 to 1 and bar1 to 2 in SERVE; ball tracks bar2
        press(3, 4);
        press(1, 3);
        check("serve_bar2_moved", int'(bar2_x), 1);
        check("serve_bar1_moved", int'(bar1_x), 2);
        check_ball("serve_track", 2, 3);
        START = 1'b1; step(); START = 1'b0;
        check("play_from_bar2", int'(state), 2);
        press(2, 4);
        check("bar2_back", int'(bar2_x), 5);

        // leftmost hit on bar1, then rightmost hit on bar2 at (7,3)
        wait_y("reach_bar1", 12, 100);
        check("reach_bar1_x", int'(ball_x), 2);
        repeat (BALL_DIV) step();
        check_ball("bar1_hold", 2, 12);
        repeat (BALL_DIV) step();
        check_ball("bar1_left_dx", 1, 11);
        wait_y("reach_bar2", 3, 100);
        check("reach_bar2_x", int'(ball_x), 7);
        repeat (BALL_DIV) step();
        check_ball("bar2_hold", 7, 3);
        repeat (BALL_DIV) step();
        check_ball("wall_reflect", 6, 4);

        // move bar1 out of the way: player 2 scores at y=15
        press(0, 3);
        check("bar1_at_5", int'(bar1_x), 5);
        wait_state("pointB_state", 3, 200);
        check("pointB_pulse", int'(point_pulse), 1);
        check("pointB_score2", int'(score2), 1);
        check("pointB_score1", int'(score1), 1);
        check_ball("pointB_ball", 5, 15);
        step();
        check("pointB_serve", int'(state), 1);
        step();
        check_ball("serve_bar1", 6, 12);

        // second point for player 1 ends the game
        press(3, 5);
        check("bar2_at_0", int'(bar2_x), 0);
        START = 1'b1; step(); START = 1'b0;
        wait_state("pointC_state", 3, 200);
        check("pointC_score1", int'(score1), 2);
        step();
        check("gameover", int'(state), 4);
        press(1, 1);
        check("gameover_bar1_frozen", int'(bar1_x), 5);
        check_ball("gameover_ball", 6, 0);
        check("gameover_score1", int'(score1), 2);
        START = 1'b1; step(); START = 1'b0;
        check("restart_state", int'(state), 1);
        check("restart_score1", int'(score1), 0);
        check("restart_score2", int'(score2), 0);

        // reset mid-PLAY with score1=1, START and buttons also asserted
        step();
        START = 1'b1; step(); START = 1'b0;
        wait_state("pointD_state", 3, 200);
        check("pointD_score1", int'(score1), 1);
        step();
        START = 1'b1; step(); START = 1'b0;
        repeat (5) step();
        check("pre_reset_play", int'(state), 2);
        RST = 1'b1; START = 1'b1; PUSH = 4'hF;
        step();
        check("rst_state", int'(state), 0);
        check("rst_bar1", int'(bar1_x), 0);
        check("rst_bar2", int'(bar2_x), 5);
        check_ball("rst_ball", 1, 12);
        check("rst_score1", int'(score1), 0);
        check("rst_score2", int'(score2), 0);
        check("rst_pulse", int'(point_pulse), 0);
        RST = 1'b0; START = 1'b0; PUSH = 4'h0;

        // random play against the model
        for (int n = 0; n < 20000; n++) begin
            RST   = ($urandom_range(0, 999) == 0);
            START = ($urandom_range(0, 7) == 0);
            PUSH  = 4'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
